alu_sweep_sequencer: RTL and testbench

Synthesizable initiator for the 32-bit ALU. It accepts one operand pair over a valid/ready handshake and drives ALU_SEL through the opcode space in ascending order. For each opcode it registers ALU_OUT and the five flags, and streams one result record per opcode over a second valid/ready handshake. It sits between a command source and the combinational ALU, replacing bench-driven stimulus in hardware self-test and batch-evaluation paths.

---
 rtl/alu_sweep_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sweep_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_sequencer.sv
// rtl/alu_sweep_sequencer.sv - sweeps ALU_SEL over all opcodes for one operand pair and streams one result record per opcode
// Optional macro ALU_SEQ_OP_MASK_EN: restricts the sweep to opcodes enabled in in_sel_mask.
module alu_sweep_sequencer #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
`ifdef ALU_SEQ_OP_MASK_EN
  input  logic [(1<<SEL_W)-1:0] in_sel_mask,
`endif
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [SEL_W-1:0]      alu_sel,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  input  logic                  alu_overflow,
  input  logic                  alu_underflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SEL_W-1:0]      res_sel,
  output logic [WIDTH-1:0]      res_data,
  output logic [4:0]            res_flags,
  output logic                  res_last,
  output logic                  busy
);
  localparam int NOPS = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic               res_valid_q, res_valid_d;
  logic [SEL_W-1:0]   res_sel_q, res_sel_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic [4:0]         res_flags_q, res_flags_d;
  logic               res_last_q, res_last_d;

  logic [NOPS-1:0]    accept_mask, sweep_mask;
  logic [SEL_W-1:0]   first_sel, next_sel;
  logic               has_next;

`ifdef ALU_SEQ_OP_MASK_EN
  logic [NOPS-1:0]    op_mask_q, op_mask_d;
  assign accept_mask = in_sel_mask;
  assign sweep_mask  = op_mask_q;
`else
  assign accept_mask = '1;
  assign sweep_mask  = '1;
`endif

  // Lowest enabled opcode for a new sweep, and lowest enabled opcode above the current one.
  always_comb begin
    first_sel = '0;
    next_sel  = alu_sel_q;
    has_next  = 1'b0;
    for (int i = NOPS - 1; i >= 0; i--) begin
      if (accept_mask[i]) first_sel = SEL_W'(i);
      if (sweep_mask[i] && (i > int'(alu_sel_q))) begin
        next_sel = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_sel_d   = res_sel_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_last_d  = res_last_q;
`ifdef ALU_SEQ_OP_MASK_EN
    op_mask_d   = op_mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_a_d = in_a;
          alu_b_d = in_b;
`ifdef ALU_SEQ_OP_MASK_EN
          op_mask_d = in_sel_mask;
`endif
          // An empty mask consumes the operands but never leaves IDLE.
          if (|accept_mask) begin
            alu_sel_d  = first_sel;
            in_ready_d = 1'b0;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        res_data_d  = alu_out;
        res_flags_d = {alu_underflow, alu_overflow, alu_negative, alu_zero, alu_carry};
        res_sel_d   = alu_sel_q;
        res_last_d  = ~has_next;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (res_last_q) begin
            in_ready_d = 1'b1;
            state_d    = IDLE;
          end else begin
            alu_sel_d = next_sel;
            state_d   = ISSUE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_sel_q   <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_last_q  <= 1'b0;
`ifdef ALU_SEQ_OP_MASK_EN
      op_mask_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_sel_q   <= res_sel_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_last_q  <= res_last_d;
`ifdef ALU_SEQ_OP_MASK_EN
      op_mask_q   <= op_mask_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = ~in_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_sel   = res_sel_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_last  = res_last_q;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// tb/tb_alu_sweep_sequencer.sv - directed self-checking bench for alu_sweep_sequencer with a behavioural ALU attached
module tb_alu_sweep_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [15:0] in_sel_mask;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry, alu_zero, alu_negative, alu_overflow, alu_underflow;
  logic        res_valid, res_ready;
  logic [3:0]  res_sel;
  logic [31:0] res_data;
  logic [4:0]  res_flags;
  logic        res_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sweep_sequencer #(.WIDTH(32), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef ALU_SEQ_OP_MASK_EN
    .in_sel_mask(in_sel_mask),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_sel(res_sel),
    .res_data(res_data), .res_flags(res_flags), .res_last(res_last), .busy(busy)
  );

  // Returns {underflow, overflow, negative, zero, carry, result}.
  function automatic logic [36:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
    logic [32:0] w;
    logic [31:0] r;
    logic c, ov, un;
    c = 1'b0; ov = 1'b0; un = 1'b0;
    case (s)
      4'd0: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[31:0];
        c  = w[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin r = a - b; un = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      default: r = a + b * {28'd0, s};
    endcase
    return {un, ov, r[31], (r == 32'd0), c, r};
  endfunction

  logic [36:0] alu_res;
  always_comb alu_res = alu_model(alu_a, alu_b, alu_sel);
  assign alu_out       = alu_res[31:0];
  assign alu_carry     = alu_res[32];
  assign alu_zero      = alu_res[33];
  assign alu_negative  = alu_res[34];
  assign alu_overflow  = alu_res[35];
  assign alu_underflow = alu_res[36];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [15:0] m);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel_mask = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_rec(input logic [3:0] sel);
    int n;
    n = 0;
    while (!(res_valid && res_sel == sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_rec_timeout", 64'(n < 100), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"},  in_ready,  1);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_last"},  res_last,  0);
    check_eq({tag, "_alu_a"},     alu_a,     0);
    check_eq({tag, "_alu_b"},     alu_b,     0);
    check_eq({tag, "_alu_sel"},   alu_sel,   0);
    check_eq({tag, "_res_sel"},   res_sel,   0);
    check_eq({tag, "_res_data"},  res_data,  0);
    check_eq({tag, "_res_flags"}, res_flags, 0);
  endtask

  localparam logic [31:0] A1 = 32'h0A0A0A0A, B1 = 32'h02020202;
  localparam logic [31:0] A2 = 32'h12345678, B2 = 32'h00000003;
  localparam logic [31:0] A3 = 32'h80000001, B3 = 32'h80000001;

  initial begin
    logic [36:0] m;
    logic [3:0]  exp_sel;
    int          n, cnt;
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel_mask = '0; res_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep, res_ready held high.
    send(A1, B1, 16'hFFFF);
    check_eq("acc_alu_sel", alu_sel, 0);
    check_eq("acc_in_ready", in_ready, 0);
    check_eq("acc_busy", busy, 1);
    check_eq("acc_alu_a", alu_a, A1);
    check_eq("acc_res_valid", res_valid, 0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check_eq($sformatf("sweep_valid_%0d", i), res_valid, 64'(i % 2));
      if (i % 2 == 1) begin
        m = alu_model(A1, B1, 4'((i - 1) / 2));
        check_eq($sformatf("sweep_sel_%0d", i), res_sel, 64'((i - 1) / 2));
        check_eq($sformatf("sweep_data_%0d", i), res_data, m[31:0]);
        check_eq($sformatf("sweep_flags_%0d", i), res_flags, m[36:32]);
        check_eq($sformatf("sweep_last_%0d", i), res_last, 64'(i == 31));
        if (i == 1) check_eq("sweep_add0", res_data, 32'h0C0C0C0C);
      end
      if (i == 31) check_eq("sweep_in_ready_31", in_ready, 0);
      if (i == 32) check_eq("sweep_in_ready_32", in_ready, 1);
    end

    // Backpressure at sel 3 with a rejected in_valid pulse during the hold.
    send(A2, B2, 16'hFFFF);
    wait_rec(4'd3);
    res_ready = 1'b0;
    m = alu_model(A2, B2, 4'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin in_valid = 1'b1; in_a = 32'hF6F6F6F6; in_b = 32'hF6F6F6F6; end
      if (i == 2) begin check_eq("bp_in_ready", in_ready, 0); in_valid = 1'b0; end
      check_eq($sformatf("bp_valid_%0d", i), res_valid, 1);
      check_eq($sformatf("bp_sel_%0d", i), res_sel, 3);
      check_eq($sformatf("bp_alu_sel_%0d", i), alu_sel, 3);
      check_eq($sformatf("bp_data_%0d", i), res_data, m[31:0]);
    end
    check_eq("bp_alu_a_kept", alu_a, A2);
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_valid", res_valid, 0);
    check_eq("bp_rel_alu_sel", alu_sel, 4);
    exp_sel = 4'd4;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (res_valid) begin
        m = alu_model(A2, B2, exp_sel);
        check_eq($sformatf("drain_sel_%0d", exp_sel), res_sel, exp_sel);
        check_eq($sformatf("drain_data_%0d", exp_sel), res_data, m[31:0]);
        if (res_last) break;
        exp_sel = exp_sel + 4'd1;
      end
    end
    check_eq("drain_end_sel", exp_sel, 15);
    @(negedge clk);
    check_eq("drain_in_ready", in_ready, 1);

    // Asynchronous reset while sel 7 is being presented.
    send(A3, B3, 16'hFFFF);
    wait_rec(4'd7);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(A1, B3, 16'hFFFF);
    @(negedge clk);
    m = alu_model(A1, B3, 4'd0);
    check_eq("restart_valid", res_valid, 1);
    check_eq("restart_sel", res_sel, 0);
    check_eq("restart_data", res_data, m[31:0]);
    check_eq("restart_flags", res_flags, m[36:32]);
    n = 0;
    while (!(res_valid && res_last) && n < 60) begin @(negedge clk); n++; end
    @(negedge clk);
    check_eq("restart_done", in_ready, 1);

`ifdef ALU_SEQ_OP_MASK_EN
    send(A1, B1, 16'h8001);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) begin
        cnt++;
        if (cnt == 1) begin
          check_eq("mask_first_sel", res_sel, 0);
          check_eq("mask_first_last", res_last, 0);
        end
        if (cnt == 2) begin
          check_eq("mask_second_sel", res_sel, 15);
          check_eq("mask_second_last", res_last, 1);
        end
      end
    end
    check_eq("mask_count", cnt, 2);
    check_eq("mask_idle", in_ready, 1);
    send(A2, B2, 16'h0000);
    check_eq("empty_in_ready", in_ready, 1);
    check_eq("empty_alu_a", alu_a, A2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check_eq("empty_count", cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
